mod_addsub_pipe: RTL and testbench
==================================

# mod_addsub_pipe

Pipelined modular adder/subtractor for the field-arithmetic datapath. It computes (a + b) mod P or (a − b) mod P for operands already reduced below P, with the operation selected per transaction. The carry/borrow chain is split across LEVEL registered stages, and both candidate results (raw and P-corrected) are carried in parallel, so no stage needs a full-width compare. It sits between operand-fetch streams and downstream multipliers/accumulators, and supersedes the fixed-mode subtract pipe.

## Interface
- P, 100: modulus, ≥ 2.
- BITS, $clog2(P): significant operand bits.
- C_DATA_WIDTH, 32: stream data width, ≥ BITS.
- CTL_BITS, 8: sideband tag width, passed through unchanged.
- LEVEL, 1: pipeline stages, 1 ≤ LEVEL ≤ BITS.
- aclk  in  1  clock.
- areset  in  1  reset: synchronous, active-high, clock aclk.
- s_tvalid  in  2  per-operand valid; [0] = a, [1] = b.
- s_tdata  in  2×C_DATA_WIDTH  operands; only bits [BITS-1:0] are used.
- s_tready  out  2  per-operand ready (identical on both bits).
- s_op  in  1  0 = add, 1 = subtract; sampled with the operands.
- s_tctl  in  CTL_BITS  tag, sampled with the operands.
- m_tvalid  out  1  result valid.
- m_tdata  out  C_DATA_WIDTH  result, zero-extended above BITS.
- m_tctl  out  CTL_BITS  tag of this result.
- m_tready  in  1  downstream ready.

## Operation
- **Widths.**
  - DAT_BITS = LEVEL·ceil(BITS/LEVEL) and W = DAT_BITS/LEVEL.
  - Operands are zero-extended to DAT_BITS. Stage g handles bits [g·W +: W].
- **Join.**
  - A transfer occurs when s_tvalid[0] & s_tvalid[1] & stage-0 ready.
  - s_tready[0] = s_tready[1] = s_tvalid[0] & s_tvalid[1] & rdy[0].
  - A lone valid operand is never accepted.
- **Candidate R1 (raw).**
  - Add: a + b, with carry c1 propagated stage to stage.
  - Sub: a − b, with borrow propagated.
- **Candidate R0 (corrected).**
  - Add: a + b − P, with a signed carry/borrow chain.
  - Sub: a − b + P.
- **Per-stage arithmetic.** Each stage computes its W-bit chunk of both candidates from the incoming carry/borrow, and registers the chunk plus the outgoing carry/borrow. Higher chunks of a, b, op and ctl travel with it.
- **Final select.**
  - Sub: output R0 if the final R1 borrow = 1, else R1.
  - Add: output R0 if its chain finishes non-negative (a + b ≥ P), else R1.
- **Result range.** The result is always in [0, P−1] when a, b < P. Operands ≥ P give undefined data but must not break the handshake.
- **Stage advance.**
  - Stage g advances when rdy[g] = ~val[g+1] | rdy[g+1], with rdy[LEVEL] = m_tready.
  - Bubbles collapse: an empty stage accepts data even while the output is stalled.
- **Reset.**
  - All val, carry and data registers clear to 0.
  - m_tvalid = 0, m_tdata = 0, m_tctl = 0.
  - Reset mid-operation discards all in-flight transactions. s_tready = 0 during the reset cycle.

## Timing
- **Latency.** LEVEL cycles from input transfer to m_tvalid with no stall, e.g. LEVEL = 1 means the result is valid the cycle after acceptance.
- **Throughput.** One result per cycle while m_tready = 1.
- **Output hold.** m_tvalid, m_tdata and m_tctl hold stable while m_tvalid & ~m_tready.
- **Stall.** With m_tready low and all stages full, s_tready deasserts in the same cycle (combinational ready chain). At most LEVEL transactions are in flight.
- **Simultaneous accept and output.** If m_tready = 1 while the pipe is full, input is accepted in the same cycle.
- **Ordering.** Strictly preserved, with m_tctl tagged per transaction.
- **Combinational paths.** The only paths are s_tvalid → s_tready and m_tready → s_tready. The output is registered.

## Structure
- **Package `mod_arith_pkg`:**
  - function `chunk_w(BITS, LEVEL)` returning the ceiling divide;
  - localparam enum `op_t {OP_ADD = 0, OP_SUB = 1}`;
  - a struct for the per-stage payload {a, b, r0, r1, c0, c1, op, ctl}.
- **Sub-module `mod_addsub_stage`:** one W-bit slice. Inputs are the chunk, the incoming carries and op; outputs are the two result chunks and the outgoing carries. Combinational; the registering stays in the top-level generate loop.

## Test plan
- P = 100, LEVEL = 1, add 60 + 70 → m_tdata = 30, one cycle later; add 50 + 50 → 0; add 99 + 0 → 99.
- P = 100, LEVEL = 3 (W = 3), sub 20 − 50 → 70; sub 50 − 20 → 30; sub 0 − 99 → 1; each after exactly 3 cycles.
- Interleaved add/sub back-to-back with ctl = 0..15, m_tready = 1 → 16 consecutive results, in order, ctl matches, no gaps.
- Only s_tvalid[0] high for 5 cycles, then s_tvalid[1] → no transfer until both are high; s_tready low throughout the lone-valid window.
- P = 2^61−1, LEVEL = 4, random m_tready at 50 % with 1000 random operands < P → all results match the model, with no loss or duplication.
- Fill the pipe with m_tready = 0, assert areset for 1 cycle, release → m_tvalid = 0 and no stale result emerges afterwards.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// ----------------------------------------------------------------------------
// mod_arith_pkg
//   Shared types and helpers for the pipelined modular add/sub datapath.
//
//   chunk_w(bits, level) : ceiling divide, width of one pipeline slice
//   op_t                 : per-transaction operation select
//   stage_pay_t          : payload registered by every pipeline stage
//
//   The payload struct is sized to package-wide maxima so it can be shared
//   by every instance regardless of its modulus. Each instance only ever
//   writes the low DAT_BITS / CTL_BITS of the fields. Upper bits stay zero
//   and are trimmed by synthesis.
// ----------------------------------------------------------------------------
package mod_arith_pkg;

    // Widest operand (after rounding up to a multiple of LEVEL) and widest
    // sideband tag that an instance may use.
    localparam int MAX_DAT_BITS = 128;
    localparam int MAX_CTL_BITS = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Per-stage payload.
    //   a, b : operands; chunks above the current stage are still consumed
    //   r0   : corrected candidate (a+b-P or a-b+P), filled chunk by chunk
    //   r1   : raw candidate (a+b or a-b), filled chunk by chunk
    //   c0   : signed carry/borrow of the r0 chain, range -1..+1
    //   c1   : carry (add) or borrow (sub) of the r1 chain
    typedef struct packed {
        logic [MAX_DAT_BITS-1:0] a;
        logic [MAX_DAT_BITS-1:0] b;
        logic [MAX_DAT_BITS-1:0] r0;
        logic [MAX_DAT_BITS-1:0] r1;
        logic [1:0]              c0;
        logic                    c1;
        op_t                     op;
        logic [MAX_CTL_BITS-1:0] ctl;
    } stage_pay_t;

    function automatic int chunk_w(input int bits, input int level);
        return (bits + level - 1) / level;
    endfunction

endpackage

// File: rtl/mod_addsub_stage.sv
// ----------------------------------------------------------------------------
// mod_addsub_stage
//   One W-bit slice of the modular add/sub carry chains. Purely
//   combinational; the top level registers the results.
//
//   Ports
//     a, b    in  W   operand chunks
//     p       in  W   matching chunk of the modulus
//     c0_in   in  2   signed carry/borrow into the corrected chain (-1..+1)
//     c1_in   in  1   carry (add) / borrow (sub) into the raw chain
//     op      in  1   OP_ADD or OP_SUB
//     r0      out W   chunk of a+b-P (add) or a-b+P (sub)
//     r1      out W   chunk of a+b (add) or a-b (sub)
//     c0_out  out 2   signed carry/borrow out of the corrected chain
//     c1_out  out 1   carry/borrow out of the raw chain
// ----------------------------------------------------------------------------
module mod_addsub_stage
    import mod_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    input  logic [1:0]   c0_in,
    input  logic         c1_in,
    input  op_t          op,
    output logic [W-1:0] r0,
    output logic [W-1:0] r1,
    output logic [1:0]   c0_out,
    output logic         c1_out
);

    // Corrected chain is evaluated in W+2 signed bits. Worst cases are
    // 2*(2^W-1)+1 and -(2^W-1)-1, so bits [W+1:W] always hold the outgoing
    // carry as a 2-bit signed value in -1..+1.
    logic signed [W+1:0] t0;
    logic        [W:0]   t1;
    logic signed [W+1:0] a_s;
    logic signed [W+1:0] b_s;
    logic signed [W+1:0] p_s;
    logic signed [W+1:0] c0_s;

    assign a_s  = $signed({2'b00, a});
    assign b_s  = $signed({2'b00, b});
    assign p_s  = $signed({2'b00, p});
    assign c0_s = $signed({{W{c0_in[1]}}, c0_in});

    always_comb begin
        t0 = '0;
        t1 = '0;
        if (op == OP_SUB) begin
            t0 = a_s - b_s + p_s + c0_s;
            // Unsigned W+1 subtraction: bit W is the outgoing borrow.
            t1 = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c1_in};
        end else begin
            t0 = a_s + b_s - p_s + c0_s;
            t1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c1_in};
        end
    end

    assign r0     = t0[W-1:0];
    assign c0_out = t0[W+1:W];
    assign r1     = t1[W-1:0];
    assign c1_out = t1[W];

endmodule

// File: rtl/mod_addsub_pipe.sv
// ----------------------------------------------------------------------------
// mod_addsub_pipe
//   Pipelined modular adder/subtractor: (a + b) mod P or (a - b) mod P for
//   operands already reduced below P. The carry chains are split over LEVEL
//   registered stages; both candidates (raw and P-corrected) travel in
//   parallel so the final choice needs only the last carry/borrow bits.
//
//   Ports
//     aclk      in  1              clock
//     areset    in  1              synchronous active-high reset
//     s_tvalid  in  2              per-operand valid, [0]=a, [1]=b
//     s_tdata   in  2*C_DATA_WIDTH {b, a}; only bits [BITS-1:0] of each used
//     s_tready  out 2              shared ready, identical on both bits
//     s_op      in  1              0 = add, 1 = subtract
//     s_tctl    in  CTL_BITS       tag, returned unchanged with the result
//     m_tvalid  out 1              result valid
//     m_tdata   out C_DATA_WIDTH   result, zero-extended above BITS
//     m_tctl    out CTL_BITS       tag of this result
//     m_tready  in  1              downstream ready
//
//   Handshake: a beat moves across an interface on a clock edge where both
//   valid and ready are high. The input side joins both operands: nothing is
//   taken until s_tvalid is 11, and then both are taken together. Ready is
//   combinational from m_tready and s_tvalid; every other output comes
//   straight from a register.
// ----------------------------------------------------------------------------
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter longint unsigned P            = 100,
    parameter int              BITS         = $clog2(P),
    parameter int              C_DATA_WIDTH = 32,
    parameter int              CTL_BITS     = 8,
    parameter int              LEVEL        = 1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [1:0]                s_tvalid,
    input  logic [2*C_DATA_WIDTH-1:0] s_tdata,
    output logic [1:0]                s_tready,
    input  logic                      s_op,
    input  logic [CTL_BITS-1:0]       s_tctl,
    output logic                      m_tvalid,
    output logic [C_DATA_WIDTH-1:0]   m_tdata,
    output logic [CTL_BITS-1:0]       m_tctl,
    input  logic                      m_tready
);

    localparam int W        = chunk_w(BITS, LEVEL);
    localparam int DAT_BITS = W * LEVEL;
    localparam logic [DAT_BITS-1:0] P_EXT = DAT_BITS'(P);

    // Stage registers, one entry per pipeline stage.
    stage_pay_t          pay_q [LEVEL];
    logic [LEVEL-1:0]    val_q;
    // rdy[g]: stage g may load this cycle. rdy[LEVEL] is the downstream.
    logic [LEVEL:0]      rdy;

    logic                join_val;
    stage_pay_t          pay0;
    logic                unused_tdata;

    // ------------------------------------------------------------------
    // Input join
    // ------------------------------------------------------------------
    assign join_val = s_tvalid[0] & s_tvalid[1];
    // Forced low in reset so nothing is reported as taken in that cycle.
    assign s_tready = {2{join_val & rdy[0] & ~areset}};

    always_comb begin
        pay0     = '0;
        pay0.a   = MAX_DAT_BITS'(s_tdata[BITS-1:0]);
        pay0.b   = MAX_DAT_BITS'(s_tdata[C_DATA_WIDTH +: BITS]);
        pay0.op  = op_t'(s_op);
        pay0.ctl = MAX_CTL_BITS'(s_tctl);
    end

    // Operand bits above BITS are ignored by definition.
    assign unused_tdata = ^s_tdata;

    // ------------------------------------------------------------------
    // Ready chain: an empty stage always loads, so bubbles collapse even
    // while the output is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        rdy        = '0;
        rdy[LEVEL] = m_tready;
        for (int i = LEVEL - 1; i >= 0; i--) begin
            rdy[i] = ~val_q[i] | rdy[i+1];
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stages: stage g resolves bits [g*W +: W] of both candidates
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < LEVEL; g++) begin : g_stage
            stage_pay_t   in_pay;
            stage_pay_t   nxt_pay;
            stage_pay_t   pay_r;
            logic         in_val;
            logic         val_r;
            logic [W-1:0] r0_c;
            logic [W-1:0] r1_c;
            logic [1:0]   c0_c;
            logic         c1_c;
            logic         unused_pay;

            if (g == 0) begin : g_first
                assign in_pay = pay0;
                assign in_val = join_val;
            end else begin : g_next
                assign in_pay = pay_q[g-1];
                assign in_val = val_q[g-1];
            end

            mod_addsub_stage #(
                .W (W)
            ) u_stage (
                .a      (in_pay.a[g*W +: W]),
                .b      (in_pay.b[g*W +: W]),
                .p      (P_EXT[g*W +: W]),
                .c0_in  (in_pay.c0),
                .c1_in  (in_pay.c1),
                .op     (in_pay.op),
                .r0     (r0_c),
                .r1     (r1_c),
                .c0_out (c0_c),
                .c1_out (c1_c)
            );

            always_comb begin
                nxt_pay               = in_pay;
                nxt_pay.r0[g*W +: W]  = r0_c;
                nxt_pay.r1[g*W +: W]  = r1_c;
                nxt_pay.c0            = c0_c;
                nxt_pay.c1            = c1_c;
            end

            always_ff @(posedge aclk) begin
                if (areset) begin
                    val_r <= 1'b0;
                    pay_r <= '0;
                end else if (rdy[g]) begin
                    val_r <= in_val;
                    // Payload only moves with a real beat, so an empty stage
                    // keeps its last contents instead of toggling.
                    if (in_val) begin
                        pay_r <= nxt_pay;
                    end
                end
            end

            assign pay_q[g] = pay_r;
            assign val_q[g] = val_r;

            // Chunks already consumed and bits above DAT_BITS are dead here.
            assign unused_pay = ^pay_r;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Final select, taken from the last stage registers only.
    //   Sub: a borrow out of a-b means the result is negative -> use a-b+P.
    //   Add: a non-negative a+b-P chain means a+b >= P -> use a+b-P.
    // After reset the last stage holds an all-zero add, which selects r0=0.
    // ------------------------------------------------------------------
    logic sel_r0;

    assign sel_r0 = (pay_q[LEVEL-1].op == OP_SUB) ? pay_q[LEVEL-1].c1
                                                  : ~pay_q[LEVEL-1].c0[1];

    assign m_tvalid = val_q[LEVEL-1];
    assign m_tdata  = C_DATA_WIDTH'(sel_r0 ? pay_q[LEVEL-1].r0[BITS-1:0]
                                           : pay_q[LEVEL-1].r1[BITS-1:0]);
    assign m_tctl   = pay_q[LEVEL-1].ctl[CTL_BITS-1:0];

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_mod_addsub_pipe
//   Three instances: P=100/LEVEL=1, P=100/LEVEL=3, P=2^61-1/LEVEL=4.
//   Directed vectors from a table, then hand-written sequences for
//   back-to-back ordering, the operand join, random back-pressure and reset.
// ----------------------------------------------------------------------------
module tb_mod_addsub_pipe;

    localparam longint unsigned P_SMALL = 64'd100;
    localparam longint unsigned P_BIG   = 64'h1FFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    // ---------------- DUT signals (index = instance) ----------------
    logic [1:0]   s_tvalid [3];
    logic [127:0] s_tdata  [3];
    logic [1:0]   s_tready [3];
    logic         s_op     [3];
    logic [7:0]   s_tctl   [3];
    logic         m_tvalid [3];
    logic [63:0]  m_tdata  [3];
    logic [7:0]   m_tctl   [3];
    logic         m_tready [3];

    int lvl [3] = '{1, 3, 4};

    mod_addsub_pipe #(.P(P_SMALL), .C_DATA_WIDTH(64), .CTL_BITS(8), .LEVEL(1)) u_dut0 (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid[0]), .s_tdata(s_tdata[0]), .s_tready(s_tready[0]),
        .s_op(s_op[0]), .s_tctl(s_tctl[0]),
        .m_tvalid(m_tvalid[0]), .m_tdata(m_tdata[0]), .m_tctl(m_tctl[0]),
        .m_tready(m_tready[0])
    );

    mod_addsub_pipe #(.P(P_SMALL), .C_DATA_WIDTH(64), .CTL_BITS(8), .LEVEL(3)) u_dut1 (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid[1]), .s_tdata(s_tdata[1]), .s_tready(s_tready[1]),
        .s_op(s_op[1]), .s_tctl(s_tctl[1]),
        .m_tvalid(m_tvalid[1]), .m_tdata(m_tdata[1]), .m_tctl(m_tctl[1]),
        .m_tready(m_tready[1])
    );

    mod_addsub_pipe #(.P(P_BIG), .C_DATA_WIDTH(64), .CTL_BITS(8), .LEVEL(4)) u_dut2 (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid[2]), .s_tdata(s_tdata[2]), .s_tready(s_tready[2]),
        .s_op(s_op[2]), .s_tctl(s_tctl[2]),
        .m_tvalid(m_tvalid[2]), .m_tdata(m_tdata[2]), .m_tctl(m_tctl[2]),
        .m_tready(m_tready[2])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [71:0] exp_q [$];   // {ctl, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic on 64-bit values.
    function automatic longint unsigned model(input bit op, input longint unsigned a,
                                              input longint unsigned b, input longint unsigned p);
        longint unsigned s;
        if (op) begin
            s = (a >= b) ? (a - b) : (a + p - b);
        end else begin
            s = a + b;
            if (s >= p) s = s - p;
        end
        return s;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int              dut;
        bit              op;
        longint unsigned a;
        longint unsigned b;
        longint unsigned exp;
    } vec_t;

    vec_t vecs [14];

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            s_tvalid[d] = 2'b00;
            s_tdata[d]  = '0;
            s_op[d]     = 1'b0;
            s_tctl[d]   = '0;
            m_tready[d] = 1'b1;
        end
    endtask

    // Called at posedge+1. Sends one transaction, measures latency, checks it.
    task automatic run_single(input int d, input bit op, input longint unsigned a,
                              input longint unsigned b, input logic [7:0] ctl,
                              input longint unsigned exp);
        int n;
        s_tvalid[d] = 2'b11;
        s_tdata[d]  = {b, a};
        s_op[d]     = op;
        s_tctl[d]   = ctl;
        m_tready[d] = 1'b1;
        #1;
        check("vec_s_tready", 64'(s_tready[d]), 64'(2'b11));
        @(posedge aclk); #1;
        s_tvalid[d] = 2'b00;
        n = 1;
        while (!m_tvalid[d] && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        check("vec_latency", 64'(n), 64'(lvl[d]));
        check("vec_data", m_tdata[d], exp);
        check("vec_ctl", 64'(m_tctl[d]), 64'(ctl));
        @(posedge aclk); #1;
        check("vec_drained", 64'(m_tvalid[d]), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        longint unsigned a, b, e;
        bit op;
        int first, last, got, acc, stale, sent, recv, cyc;
        logic [71:0] item;

        vecs[0]  = '{0, 1'b0, 60, 70, 30};
        vecs[1]  = '{0, 1'b0, 50, 50, 0};
        vecs[2]  = '{0, 1'b0, 99, 0, 99};
        vecs[3]  = '{0, 1'b1, 0, 0, 0};
        vecs[4]  = '{0, 1'b1, 5, 99, 6};
        vecs[5]  = '{0, 1'b0, 99, 99, 98};
        vecs[6]  = '{1, 1'b1, 20, 50, 70};
        vecs[7]  = '{1, 1'b1, 50, 20, 30};
        vecs[8]  = '{1, 1'b1, 0, 99, 1};
        vecs[9]  = '{1, 1'b0, 64, 36, 0};
        vecs[10] = '{1, 1'b0, 99, 99, 98};
        vecs[11] = '{1, 1'b1, 99, 99, 0};
        vecs[12] = '{2, 1'b0, 64'h1FFF_FFFF_FFFF_FFFE, 1, 0};
        vecs[13] = '{2, 1'b1, 0, 1, 64'h1FFF_FFFF_FFFF_FFFE};

        // ---- reset ----
        idle_all();
        areset = 1'b1;
        s_tvalid[0] = 2'b11;
        repeat (2) @(posedge aclk);
        #1;
        check("reset_s_tready", 64'(s_tready[0]), 64'd0);
        for (int d = 0; d < 3; d++) begin
            check("reset_m_tvalid", 64'(m_tvalid[d]), 64'd0);
            check("reset_m_tdata", m_tdata[d], 64'd0);
            check("reset_m_tctl", 64'(m_tctl[d]), 64'd0);
        end
        s_tvalid[0] = 2'b00;
        areset = 1'b0;
        @(posedge aclk); #1;

        // ---- directed vectors ----
        for (int i = 0; i < 14; i++) begin
            run_single(vecs[i].dut, vecs[i].op, vecs[i].a, vecs[i].b, 8'(i + 8'h40), vecs[i].exp);
        end

        // ---- 16 back-to-back interleaved add/sub on LEVEL=3 ----
        exp_q.delete();
        first = -1; last = -1; got = 0;
        m_tready[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c < 16) begin
                a  = longint'((c * 37 + 5) % 100);
                b  = longint'((c * 53 + 11) % 100);
                op = (c % 2) == 1;
                s_tvalid[1] = 2'b11;
                s_tdata[1]  = {b, a};
                s_op[1]     = op;
                s_tctl[1]   = 8'(c);
                exp_q.push_back({8'(c), model(op, a, b, P_SMALL)});
                #1;
                check("b2b_s_tready", 64'(s_tready[1]), 64'(2'b11));
            end else begin
                s_tvalid[1] = 2'b00;
            end
            @(posedge aclk); #1;
            if (m_tvalid[1]) begin
                if (first < 0) first = c;
                last = c;
                got++;
                if (exp_q.size() == 0) begin
                    check("b2b_spurious", 64'd1, 64'd0);
                end else begin
                    item = exp_q.pop_front();
                    check("b2b_data", m_tdata[1], item[63:0]);
                    check("b2b_ctl", 64'(m_tctl[1]), 64'(item[71:64]));
                end
            end
        end
        check("b2b_count", 64'(got), 64'd16);
        check("b2b_first_cycle", 64'(first), 64'(lvl[1] - 1));
        check("b2b_no_gaps", 64'(last - first), 64'd15);

        // ---- lone valid operand on LEVEL=1 ----
        m_tready[0] = 1'b1;
        s_tdata[0]  = {64'd34, 64'd12};
        s_op[0]     = 1'b0;
        s_tctl[0]   = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            s_tvalid[0] = 2'b01;
            #1;
            check("lone_s_tready", 64'(s_tready[0]), 64'd0);
            @(posedge aclk); #1;
            check("lone_m_tvalid", 64'(m_tvalid[0]), 64'd0);
        end
        s_tvalid[0] = 2'b11;
        #1;
        check("join_s_tready", 64'(s_tready[0]), 64'(2'b11));
        @(posedge aclk); #1;
        s_tvalid[0] = 2'b00;
        check("join_m_tvalid", 64'(m_tvalid[0]), 64'd1);
        check("join_m_tdata", m_tdata[0], 64'd46);
        check("join_m_tctl", 64'(m_tctl[0]), 64'h5A);
        @(posedge aclk); #1;

        // ---- random back-pressure, P = 2^61-1, LEVEL=4 ----
        exp_q.delete();
        sent = 0; recv = 0; cyc = 0;
        a = P_BIG - 1; b = P_BIG - 1; op = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            s_tvalid[2] = (sent < 1000 && $urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
            s_tdata[2]  = {b, a};
            s_op[2]     = op;
            s_tctl[2]   = 8'(sent);
            m_tready[2] = $urandom_range(0, 1) == 1;
            #1;
            if (m_tvalid[2] && m_tready[2]) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious", 64'd1, 64'd0);
                end else begin
                    item = exp_q.pop_front();
                    check("rnd_data", m_tdata[2], item[63:0]);
                    check("rnd_ctl", 64'(m_tctl[2]), 64'(item[71:64]));
                end
                recv++;
            end
            if (s_tvalid[2] == 2'b11 && s_tready[2] == 2'b11) begin
                exp_q.push_back({8'(sent), model(op, a, b, P_BIG)});
                sent++;
                case (sent)
                    1:       begin a = 0;         b = P_BIG - 1; op = 1'b1; end
                    2:       begin a = P_BIG - 1; b = 0;         op = 1'b1; end
                    3:       begin a = 0;         b = 0;         op = 1'b1; end
                    default: begin
                        a  = {$urandom(), $urandom()} % P_BIG;
                        b  = {$urandom(), $urandom()} % P_BIG;
                        op = $urandom_range(0, 1) == 1;
                    end
                endcase
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_tvalid[2] = 2'b00;
        m_tready[2] = 1'b1;
        check("rnd_sent", 64'(sent), 64'd1000);
        check("rnd_recv", 64'(recv), 64'd1000);
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        stale = 0;
        repeat (8) begin
            @(posedge aclk); #1;
            if (m_tvalid[2]) stale++;
        end
        check("rnd_no_duplicate", 64'(stale), 64'd0);

        // ---- fill with stall, check ready path, reset mid-flight (LEVEL=3) ----
        m_tready[1] = 1'b0;
        s_tvalid[1] = 2'b11;
        s_tdata[1]  = {64'd20, 64'd10};
        s_op[1]     = 1'b0;
        s_tctl[1]   = 8'h77;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (s_tready[1] == 2'b11) acc++;
            @(posedge aclk); #1;
        end
        check("stall_accepted", 64'(acc), 64'(lvl[1]));
        check("stall_s_tready", 64'(s_tready[1]), 64'd0);
        check("stall_m_tvalid", 64'(m_tvalid[1]), 64'd1);
        m_tready[1] = 1'b1;
        #1;
        check("full_pass_s_tready", 64'(s_tready[1]), 64'(2'b11));
        m_tready[1] = 1'b0;
        #1;
        areset = 1'b1;
        #1;
        check("rst_cycle_s_tready", 64'(s_tready[1]), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        s_tvalid[1] = 2'b00;
        check("rst_m_tvalid", 64'(m_tvalid[1]), 64'd0);
        check("rst_m_tdata", m_tdata[1], 64'd0);
        check("rst_m_tctl", 64'(m_tctl[1]), 64'd0);
        m_tready[1] = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge aclk); #1;
            if (m_tvalid[1]) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
